// File: rtl/vx_barrier_ctl_pkg.sv
// Shared types for the per-core barrier scheduler: sizing, entry state and global FSM states.
package vx_barrier_ctl_pkg;

  localparam int unsigned NUM_WARPS    = 4;
  localparam int unsigned NUM_BARRIERS = 4;
  localparam int unsigned NW_WIDTH     = 2;
  localparam int unsigned NB_WIDTH     = 2;

  typedef struct packed {
    logic [NW_WIDTH-1:0]  count;
    logic [NUM_WARPS-1:0] wmask;
    logic                 is_global;
    logic [NW_WIDTH-1:0]  size_m1;
    logic                 gpend;     // locally complete, waiting for the cluster network
  } bar_entry_t;

  typedef enum logic [1:0] {
    BAR_IDLE,
    BAR_REQ,
    BAR_WAIT
  } bar_state_e;

  // Priority encoder: index of the lowest set bit (0 when none set).
  function automatic logic [NB_WIDTH-1:0] lowest_set(input logic [NUM_BARRIERS-1:0] vec);
    logic [NB_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
      if (vec[i]) idx = NB_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_barrier_ctl_if.sv
// Warp-control side and cluster barrier-network side signals of the barrier scheduler.
interface vx_barrier_ctl_if;

  logic                                         req_valid;
  logic [vx_barrier_ctl_pkg::NW_WIDTH-1:0]      req_wid;
  logic [vx_barrier_ctl_pkg::NB_WIDTH-1:0]      req_id;
  logic [vx_barrier_ctl_pkg::NW_WIDTH-1:0]      req_size_m1;
  logic                                         req_is_global;
  logic [vx_barrier_ctl_pkg::NUM_WARPS-1:0]     active_wmask;
  logic [vx_barrier_ctl_pkg::NUM_WARPS-1:0]     stalled;
  logic                                         release_valid;
  logic [vx_barrier_ctl_pkg::NUM_WARPS-1:0]     release_mask;
  logic                                         gbar_req_valid;
  logic [vx_barrier_ctl_pkg::NB_WIDTH-1:0]      gbar_req_id;
  logic [vx_barrier_ctl_pkg::NW_WIDTH-1:0]      gbar_req_size_m1;
  logic                                         gbar_req_ready;
  logic                                         gbar_rsp_valid;
  logic [vx_barrier_ctl_pkg::NB_WIDTH-1:0]      gbar_rsp_id;

  modport master (
    output req_valid, req_wid, req_id, req_size_m1, req_is_global, active_wmask,
    output gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    input  stalled, release_valid, release_mask,
    input  gbar_req_valid, gbar_req_id, gbar_req_size_m1
  );

  modport slave (
    input  req_valid, req_wid, req_id, req_size_m1, req_is_global, active_wmask,
    input  gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    output stalled, release_valid, release_mask,
    output gbar_req_valid, gbar_req_id, gbar_req_size_m1
  );

endinterface

// File: rtl/vx_barrier_ctl_entry.sv
// One barrier id: arrival counting, waiting-warp mask and completion compare.
module vx_barrier_ctl_entry
  import vx_barrier_ctl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [NW_WIDTH-1:0]  wid,
  input  logic [NW_WIDTH-1:0]  size_m1,
  input  logic                 is_global,
  input  logic [NUM_WARPS-1:0] active_wmask,
  input  logic                 gclear,
  output bar_entry_t           entry,
  output logic [NUM_WARPS-1:0] done_mask,
  output logic                 stall
);

  bar_entry_t           entry_q, entry_d;
  logic [NUM_WARPS-1:0] new_mask;

  assign new_mask = entry_q.wmask | (NUM_WARPS'(1) << wid);
  assign entry    = entry_q;

  // Next entry state; a local completion hands the full mask out and empties the entry.
  always_comb begin
    entry_d   = entry_q;
    done_mask = '0;
    stall     = 1'b0;
    if (gclear) begin
      entry_d = '0;
    end else if (arrive) begin
      entry_d.size_m1   = size_m1;
      entry_d.is_global = is_global;
      if (is_global) begin
        entry_d.wmask = new_mask;
        stall         = 1'b1;
        // Local completion of a global barrier only queues it for the network.
        if ((new_mask & active_wmask) == active_wmask) entry_d.gpend = 1'b1;
      end else if (entry_q.count == size_m1) begin
        done_mask = new_mask;
        entry_d   = '0;
      end else begin
        entry_d.count = entry_q.count + NW_WIDTH'(1);
        entry_d.wmask = new_mask;
        stall         = 1'b1;
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

endmodule

// File: rtl/vx_barrier_ctl.sv
// Per-core barrier scheduler: stalls arriving warps, releases groups, forwards global barriers.
module vx_barrier_ctl
  import vx_barrier_ctl_pkg::*;
(
  input logic           clk,
  input logic           reset,
  vx_barrier_ctl_if.slave bar
);

  bar_entry_t           ent       [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] done_mask [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] arrive, stall, gclear, gpend_vec, busy_vec, global_vec;

  bar_state_e          state_q, state_d;
  logic [NB_WIDTH-1:0] gid_q, gid_d;
  logic [NW_WIDTH-1:0] gsize_q, gsize_d;
  logic                gmatch, req_valid;

  logic [NUM_WARPS-1:0] stalled_q, stalled_d, rel_mask_q, rel_d, stall_set;
  logic                 rel_valid_q;

  for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
    assign arrive[g] = bar.req_valid && (bar.req_id == NB_WIDTH'(g));
    vx_barrier_ctl_entry u_entry (
      .clk          (clk),
      .reset        (reset),
      .arrive       (arrive[g]),
      .wid          (bar.req_wid),
      .size_m1      (bar.req_size_m1),
      .is_global    (bar.req_is_global),
      .active_wmask (bar.active_wmask),
      .gclear       (gclear[g]),
      .entry        (ent[g]),
      .done_mask    (done_mask[g]),
      .stall        (stall[g])
    );
    assign gpend_vec[g]  = ent[g].gpend;
    assign busy_vec[g]   = (|ent[g].wmask) || (|ent[g].count);
    assign global_vec[g] = ent[g].is_global;
  end

  assign gmatch = (state_q == BAR_WAIT) && bar.gbar_rsp_valid && (bar.gbar_rsp_id == gid_q);

  // Merge local and global releases; released warps leave the stall mask together.
  always_comb begin
    rel_d = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) rel_d |= done_mask[b];
    if (gmatch) rel_d |= ent[gid_q].wmask;
    stall_set = '0;
    if (|stall) stall_set = NUM_WARPS'(1) << bar.req_wid;
    stalled_d = (stalled_q | stall_set) & ~rel_d;
  end

  // Registered release pulse and stall mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stalled_q   <= '0;
      rel_mask_q  <= '0;
      rel_valid_q <= 1'b0;
    end else begin
      stalled_q   <= stalled_d;
      rel_mask_q  <= rel_d;
      rel_valid_q <= |rel_d;
    end
  end

  // Global FSM state and latched in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BAR_IDLE;
      gid_q   <= '0;
      gsize_q <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      gsize_q <= gsize_d;
    end
  end

  // Global FSM next state: one barrier in flight, lowest pending id first.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    gsize_d = gsize_q;
    case (state_q)
      BAR_IDLE: begin
        if (|gpend_vec) begin
          gid_d   = lowest_set(gpend_vec);
          gsize_d = ent[gid_d].size_m1;
          state_d = BAR_REQ;
        end
      end
      BAR_REQ:  if (bar.gbar_req_ready) state_d = BAR_WAIT;
      BAR_WAIT: if (gmatch) state_d = BAR_IDLE;
      default:  state_d = BAR_IDLE;
    endcase
  end

  // Global FSM outputs.
  always_comb begin
    req_valid = (state_q == BAR_REQ);
    gclear    = '0;
    if (gmatch) gclear[gid_q] = 1'b1;
  end

  assign bar.stalled          = stalled_q;
  assign bar.release_valid    = rel_valid_q;
  assign bar.release_mask     = rel_mask_q;
  assign bar.gbar_req_valid   = req_valid;
  assign bar.gbar_req_id      = gid_q;
  assign bar.gbar_req_size_m1 = gsize_q;

  a_no_stalled_arrival: assert property (@(posedge clk) disable iff (reset)
    bar.req_valid |-> !stalled_q[bar.req_wid]);
  a_no_gpend_arrival: assert property (@(posedge clk) disable iff (reset)
    bar.req_valid |-> !gpend_vec[bar.req_id]);
  a_no_mixed_kind: assert property (@(posedge clk) disable iff (reset)
    (bar.req_valid && busy_vec[bar.req_id]) |-> (global_vec[bar.req_id] == bar.req_is_global));
  a_rsp_matches: assert property (@(posedge clk) disable iff (reset)
    ((state_q == BAR_WAIT) && bar.gbar_rsp_valid) |-> (bar.gbar_rsp_id == gid_q));

endmodule

// File: tb/tb_vx_barrier_ctl.sv
// Directed and randomized checks of the barrier scheduler against a set-based reference model.
module tb_vx_barrier_ctl;
  import vx_barrier_ctl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_barrier_ctl_if bar ();

  vx_barrier_ctl dut (
    .clk   (clk),
    .reset (reset),
    .bar   (bar)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_stalled, m_rel, m_free, m_bit;
  logic [3:0]  m_arr [4];
  int unsigned m_sz  [4];
  int          w, id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arrive(input int wid, input int bid, input int sz, input logic glob);
    bar.req_valid     = 1'b1;
    bar.req_wid       = NW_WIDTH'(wid);
    bar.req_id        = NB_WIDTH'(bid);
    bar.req_size_m1   = NW_WIDTH'(sz);
    bar.req_is_global = glob;
    tick();
    bar.req_valid     = 1'b0;
  endtask

  task automatic rsp(input int bid);
    bar.gbar_rsp_valid = 1'b1;
    bar.gbar_rsp_id    = NB_WIDTH'(bid);
    tick();
    bar.gbar_rsp_valid = 1'b0;
  endtask

  task automatic accept();
    bar.gbar_req_ready = 1'b1;
    tick();
    bar.gbar_req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bar.req_valid      = 1'b0;
    bar.req_wid        = '0;
    bar.req_id         = '0;
    bar.req_size_m1    = '0;
    bar.req_is_global  = 1'b0;
    bar.active_wmask   = '0;
    bar.gbar_req_ready = 1'b0;
    bar.gbar_rsp_valid = 1'b0;
    bar.gbar_rsp_id    = '0;
    @(negedge clk);
    chk("rst_stalled", 32'(bar.stalled), 32'h0);
    chk("rst_rel_valid", 32'(bar.release_valid), 32'h0);
    chk("rst_rel_mask", 32'(bar.release_mask), 32'h0);
    chk("rst_greq", 32'(bar.gbar_req_valid), 32'h0);
    reset = 1'b0;
    tick();

    // Local id 1, four warps.
    arrive(0, 1, 3, 1'b0);
    chk("loc_stall_w0", 32'(bar.stalled), 32'b0001);
    chk("loc_norel_w0", 32'(bar.release_valid), 32'h0);
    arrive(1, 1, 3, 1'b0);
    chk("loc_stall_w1", 32'(bar.stalled), 32'b0011);
    arrive(2, 1, 3, 1'b0);
    chk("loc_stall_w2", 32'(bar.stalled), 32'b0111);
    arrive(3, 1, 3, 1'b0);
    chk("loc_rel_valid", 32'(bar.release_valid), 32'h1);
    chk("loc_rel_mask", 32'(bar.release_mask), 32'b1111);
    chk("loc_rel_stalled", 32'(bar.stalled), 32'h0);
    tick();
    chk("loc_rel_pulse", 32'(bar.release_valid), 32'h0);

    // Size one releases immediately.
    arrive(2, 3, 0, 1'b0);
    chk("sz0_rel_mask", 32'(bar.release_mask), 32'b0100);
    chk("sz0_stalled", 32'(bar.stalled), 32'h0);
    tick();

    // Global id 0 with back-pressure on the request.
    bar.active_wmask = 4'b0011;
    arrive(0, 0, 1, 1'b1);
    chk("g_stall_w0", 32'(bar.stalled), 32'b0001);
    arrive(1, 0, 1, 1'b1);
    chk("g_req_early", 32'(bar.gbar_req_valid), 32'h0);
    chk("g_stall_w1", 32'(bar.stalled), 32'b0011);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("g_req_hold", 32'(bar.gbar_req_valid), 32'h1);
      chk("g_req_id", 32'(bar.gbar_req_id), 32'h0);
      chk("g_req_size", 32'(bar.gbar_req_size_m1), 32'h1);
      tick();
    end
    accept();
    chk("g_req_drop", 32'(bar.gbar_req_valid), 32'h0);
    chk("g_wait_norel", 32'(bar.release_valid), 32'h0);
    tick();
    rsp(0);
    chk("g_rel_mask", 32'(bar.release_mask), 32'b0011);
    chk("g_rel_stalled", 32'(bar.stalled), 32'h0);
    tick();

    // Pending globals queue behind an in-flight one and issue lowest id first.
    bar.active_wmask = 4'b0001;
    arrive(0, 0, 0, 1'b1);
    tick();
    chk("q_req0_id", 32'(bar.gbar_req_id), 32'h0);
    accept();
    bar.active_wmask = 4'b0100;
    arrive(2, 3, 2, 1'b1);
    bar.active_wmask = 4'b0010;
    arrive(1, 1, 1, 1'b1);
    tick();
    chk("q_busy_noreq", 32'(bar.gbar_req_valid), 32'h0);
    rsp(0);
    chk("q_rel0", 32'(bar.release_mask), 32'b0001);
    tick();
    chk("q_req1_valid", 32'(bar.gbar_req_valid), 32'h1);
    chk("q_req1_id", 32'(bar.gbar_req_id), 32'h1);
    chk("q_req1_size", 32'(bar.gbar_req_size_m1), 32'h1);
    accept();
    tick();
    chk("q_second_held", 32'(bar.gbar_req_valid), 32'h0);
    rsp(1);
    chk("q_rel1", 32'(bar.release_mask), 32'b0010);
    tick();
    chk("q_req3_id", 32'(bar.gbar_req_id), 32'h3);
    chk("q_req3_size", 32'(bar.gbar_req_size_m1), 32'h2);
    accept();
    rsp(3);
    chk("q_rel3", 32'(bar.release_mask), 32'b0100);
    chk("q_stalled_clr", 32'(bar.stalled), 32'h0);
    tick();

    // Local and global release merge into one pulse.
    bar.active_wmask = 4'b0001;
    arrive(0, 0, 0, 1'b1);
    tick();
    accept();
    arrive(1, 2, 1, 1'b0);
    chk("m_stalled", 32'(bar.stalled), 32'b0011);
    bar.gbar_rsp_valid = 1'b1;
    bar.gbar_rsp_id    = '0;
    arrive(2, 2, 1, 1'b0);
    bar.gbar_rsp_valid = 1'b0;
    chk("m_rel_valid", 32'(bar.release_valid), 32'h1);
    chk("m_rel_mask", 32'(bar.release_mask), 32'b0111);
    chk("m_stalled_clr", 32'(bar.stalled), 32'h0);
    tick();
    chk("m_single_pulse", 32'(bar.release_valid), 32'h0);

    // Reset while waiting on the network.
    bar.active_wmask = 4'b0011;
    arrive(0, 0, 1, 1'b1);
    arrive(1, 0, 1, 1'b1);
    tick();
    accept();
    chk("r_stalled_pre", 32'(bar.stalled), 32'b0011);
    reset = 1'b1;
    #1;
    chk("r_stalled", 32'(bar.stalled), 32'h0);
    chk("r_rel_valid", 32'(bar.release_valid), 32'h0);
    chk("r_rel_mask", 32'(bar.release_mask), 32'h0);
    chk("r_greq", 32'(bar.gbar_req_valid), 32'h0);
    #1;
    reset = 1'b0;
    rsp(0);
    chk("r_late_rsp_rel", 32'(bar.release_valid), 32'h0);
    chk("r_late_rsp_stall", 32'(bar.stalled), 32'h0);
    tick();
    chk("r_late_rsp_greq", 32'(bar.gbar_req_valid), 32'h0);

    // Randomized local barriers against a set model; a deadlock is cleared by reset.
    m_stalled = '0;
    m_rel     = '0;
    for (int b = 0; b < 4; b++) begin
      m_arr[b] = '0;
      m_sz[b]  = 0;
    end
    for (int i = 0; i < 400; i++) begin
      chk("rnd_stalled", 32'(bar.stalled), 32'(m_stalled));
      chk("rnd_rel_valid", 32'(bar.release_valid), 32'(m_rel != 0));
      chk("rnd_rel_mask", 32'(bar.release_mask), 32'(m_rel));
      m_rel  = '0;
      m_free = ~m_stalled;
      if ($urandom_range(0, 3) != 0) begin
        if (m_free == 4'b0000) begin
          reset = 1'b1;
          #2;
          reset = 1'b0;
          m_stalled = '0;
          for (int b = 0; b < 4; b++) m_arr[b] = '0;
        end else begin
          w = $urandom_range(0, 3);
          while (!m_free[w]) w = $urandom_range(0, 3);
          id = $urandom_range(0, 3);
          if (m_arr[id] == 4'b0000) m_sz[id] = $urandom_range(0, 3);
          m_bit = 4'b0001 << w;
          bar.req_valid     = 1'b1;
          bar.req_wid       = NW_WIDTH'(w);
          bar.req_id        = NB_WIDTH'(id);
          bar.req_size_m1   = NW_WIDTH'(m_sz[id]);
          bar.req_is_global = 1'b0;
          // Group is complete once size_m1 warps were already waiting.
          if ($countones(m_arr[id]) == int'(m_sz[id])) begin
            m_rel     = m_arr[id] | m_bit;
            m_stalled = m_stalled & ~m_rel;
            m_arr[id] = '0;
          end else begin
            m_arr[id] = m_arr[id] | m_bit;
            m_stalled = m_stalled | m_bit;
          end
        end
      end
      tick();
      bar.req_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
